i2c_master_read_bit: RTL and testbench

//   Master-side bit receiver for the I2C controller; counterpart of the master bit writer.
//   On command it generates one SCL pulse with SDA released and samples SDA while SCL is high.
//   It returns either a data bit or the slave's ACK/NACK.
//   It checks SDA stability during the high phase and honours slave clock stretching.
//   The byte-level read FSM drives it through the same go/command/finish handshake as the writer.

---
 rtl/i2c_master_read_bit_if.sv | 32 +++
 rtl/i2c_master_read_bit.sv | 181 ++++++++++++++++++
 tb/tb_i2c_master_read_bit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/i2c_master_read_bit_if.sv
// Interface bundling the bit receiver's command handshake and I2C line signals.
//   go, command       : start request and read command (00 NOP, 01 READ_DATA, 10 READ_ACK)
//   finish            : high when idle and results are valid
//   data_out          : received data bit, or 1 = ACK / 0 = NACK for READ_ACK
//   bus_error         : SDA changed while SCL was high during the last bit
//   timeout           : last bit aborted by the clock-stretch timeout
//   scl_o, sda_o      : open-drain drives (0 = pull low, 1 = release)
//   scl_i, sda_i      : synchronised sensed bus lines
// The master modport belongs to the byte-level FSM and pad side, and the slave modport
// belongs to the bit receiver.
interface i2c_master_read_bit_if;
  logic       go;
  logic [1:0] command;
  logic       finish;
  logic       data_out;
  logic       bus_error;
  logic       timeout;
  logic       scl_o;
  logic       sda_o;
  logic       scl_i;
  logic       sda_i;

  modport master (
    output go, command, scl_i, sda_i,
    input  finish, data_out, bus_error, timeout, scl_o, sda_o
  );

  modport slave (
    input  go, command, scl_i, sda_i,
    output finish, data_out, bus_error, timeout, scl_o, sda_o
  );
endinterface

// File: rtl/i2c_master_read_bit.sv
// Master-side I2C bit receiver. A go/command handshake starts one SCL pulse with SDA
// released. SDA is sampled at the start of the SCL high phase and must stay stable while
// SCL is high. The result is either the data bit or the slave's ACK/NACK. Slave clock
// stretching is honoured up to STRETCH_TIMEOUT clocks.
// Ports:
//   clock : system clock, posedge
//   reset : synchronous, active-high
//   bus   : i2c_master_read_bit_if.slave (handshake, results, SCL/SDA drive and sense)
module i2c_master_read_bit #(
  parameter int unsigned DIVIDER         = 4,
  parameter int unsigned STRETCH_TIMEOUT = 1024
) (
  input logic                  clock,
  input logic                  reset,
  i2c_master_read_bit_if.slave bus
);

  localparam int unsigned QW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned WW = (STRETCH_TIMEOUT > 1) ? $clog2(STRETCH_TIMEOUT) : 1;
  localparam logic [QW-1:0] QLast = QW'(DIVIDER - 1);
  localparam logic [WW-1:0] WLast = WW'(STRETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLow1,
    StLow2,
    StHighWait,
    StHigh1,
    StHigh2
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          is_ack_q, is_ack_d;
  logic          sample_q, sample_d;
  logic          err_q, err_d;
  logic          scl_q, scl_d;
  logic          finish_q, finish_d;
  logic          data_q, data_d;
  logic          bus_err_q, bus_err_d;
  logic          timeout_q, timeout_d;

  logic qlast;
  logic mismatch;
  logic read_cmd;

  assign qlast    = (qcnt_q == QLast);
  assign mismatch = (bus.sda_i != sample_q);
  assign read_cmd = (bus.command == 2'b01) || (bus.command == 2'b10);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    wcnt_d    = wcnt_q;
    is_ack_d  = is_ack_q;
    sample_d  = sample_q;
    err_d     = err_q;
    scl_d     = scl_q;
    finish_d  = finish_q;
    data_d    = data_q;
    bus_err_d = bus_err_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        // NOP and reserved commands leave the bus and the results untouched.
        if (bus.go && read_cmd) begin
          state_d   = StLow1;
          qcnt_d    = '0;
          is_ack_d  = (bus.command == 2'b10);
          err_d     = 1'b0;
          scl_d     = 1'b0;
          finish_d  = 1'b0;
          data_d    = 1'b0;
          bus_err_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StLow1: begin
        if (qlast) begin
          state_d = StLow2;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      StLow2: begin
        if (qlast) begin
          state_d = StHighWait;
          qcnt_d  = '0;
          wcnt_d  = '0;
          scl_d   = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      StHighWait: begin
        if (bus.scl_i) begin
          state_d = StHigh1;
          qcnt_d  = '0;
        end else if (wcnt_q == WLast) begin
          // Abort with SCL released so a stuck slave is not held low by this master too.
          state_d   = StIdle;
          timeout_d = 1'b1;
          finish_d  = 1'b1;
          scl_d     = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      StHigh1: begin
        if (qcnt_q == '0) begin
          sample_d = bus.sda_i;
        end else if (mismatch) begin
          err_d = 1'b1;
        end
        if (qlast) begin
          state_d = StHigh2;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      StHigh2: begin
        if (mismatch) begin
          err_d = 1'b1;
        end
        if (qlast) begin
          state_d   = StIdle;
          scl_d     = 1'b0;
          finish_d  = 1'b1;
          // ACK is SDA pulled low by the slave, so it reads back as the inverted sample.
          data_d    = is_ack_q ? ~sample_q : sample_q;
          bus_err_d = err_q | mismatch;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      qcnt_q    <= '0;
      wcnt_q    <= '0;
      is_ack_q  <= 1'b0;
      sample_q  <= 1'b0;
      err_q     <= 1'b0;
      scl_q     <= 1'b1;
      finish_q  <= 1'b1;
      data_q    <= 1'b0;
      bus_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      wcnt_q    <= wcnt_d;
      is_ack_q  <= is_ack_d;
      sample_q  <= sample_d;
      err_q     <= err_d;
      scl_q     <= scl_d;
      finish_q  <= finish_d;
      data_q    <= data_d;
      bus_err_q <= bus_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.scl_o     = scl_q;
  assign bus.sda_o     = 1'b1;
  assign bus.finish    = finish_q;
  assign bus.data_out  = data_q;
  assign bus.bus_error = bus_err_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_i2c_master_read_bit.sv
module tb_i2c_master_read_bit;

  localparam int Div = 4;
  localparam int St  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hold  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  i2c_master_read_bit_if bus ();

  // SCL loopback with an optional slave stretch holding the line low.
  assign bus.scl_i = bus.scl_o & ~hold;

  i2c_master_read_bit #(
    .DIVIDER        (Div),
    .STRETCH_TIMEOUT(St)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one bit starting from a negedge, returns at the negedge after finish rises.
  // stretch >= St means SCL is held low forever. toggle flips SDA in the second half of
  // the high phase. busy_go pulses go with the other command while the bit is running.
  task automatic run_bit(input logic [1:0] cmd, input logic sda, input int stretch,
                         input bit toggle, input bit busy_go, input int reset_at,
                         output int lat, output int low_cnt, output bit sda_drv);
    int hi;
    hi      = 0;
    lat     = 0;
    low_cnt = 0;
    sda_drv = 1'b0;
    bus.go      = 1'b1;
    bus.command = cmd;
    bus.sda_i   = sda;
    hold        = 1'b0;
    @(negedge clock);
    bus.go = 1'b0;
    while (!bus.finish && lat < 200) begin
      lat++;
      if (!bus.scl_o) low_cnt++;
      if (!bus.sda_o) sda_drv = 1'b1;
      if (bus.scl_o) begin
        hold = (hi < stretch);
        if (toggle && hi == stretch + Div + 2) bus.sda_i = ~bus.sda_i;
        hi++;
      end
      if (busy_go && lat == 3) begin
        bus.go      = 1'b1;
        bus.command = (cmd == 2'b01) ? 2'b10 : 2'b01;
      end
      if (busy_go && lat == 5) bus.go = 1'b0;
      if (reset_at != 0 && lat == reset_at) reset = 1'b1;
      @(negedge clock);
      if (reset) begin
        reset = 1'b0;
        break;
      end
    end
    hold   = 1'b0;
    bus.go = 1'b0;
  endtask

  // Reference: SCL low for two quarter-periods, then high for the wait plus two more.
  task automatic exec_bit(input string tag, input logic [1:0] cmd, input logic sda,
                          input int stretch, input bit toggle, input bit busy_go);
    int lat, low_cnt;
    bit sda_drv, stuck;
    int exp_data;
    stuck = (stretch >= St);
    run_bit(cmd, sda, stretch, toggle, busy_go, 0, lat, low_cnt, sda_drv);
    exp_data = stuck ? 0 : ((cmd == 2'b01) ? int'(sda) : int'(!sda));
    check_eq({tag, "_latency"}, lat, stuck ? 2 * Div + St : 4 * Div + stretch + 1);
    check_eq({tag, "_scl_low"}, low_cnt, 2 * Div);
    check_eq({tag, "_sda_drive"}, int'(sda_drv), 0);
    check_eq({tag, "_data_out"}, int'(bus.data_out), exp_data);
    check_eq({tag, "_bus_error"}, int'(bus.bus_error), (!stuck && toggle) ? 1 : 0);
    check_eq({tag, "_timeout"}, int'(bus.timeout), stuck ? 1 : 0);
    check_eq({tag, "_scl_end"}, int'(bus.scl_o), stuck ? 1 : 0);
  endtask

  // NOP-style request: nothing may move for several cycles.
  task automatic exec_nop(input string tag, input logic [1:0] cmd);
    logic scl0, d0, b0, t0;
    bit moved;
    scl0  = bus.scl_o;
    d0    = bus.data_out;
    b0    = bus.bus_error;
    t0    = bus.timeout;
    moved = 1'b0;
    bus.go      = 1'b1;
    bus.command = cmd;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.go = 1'b0;
      if (!bus.finish || bus.scl_o != scl0 || bus.data_out != d0 ||
          bus.bus_error != b0 || bus.timeout != t0) moved = 1'b1;
    end
    check_eq({tag, "_quiet"}, int'(moved), 0);
  endtask

  initial begin
    int lat, low_cnt;
    bit sda_drv;
    bus.go      = 1'b0;
    bus.command = 2'b00;
    bus.sda_i   = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check_eq("rst_finish", int'(bus.finish), 1);
    check_eq("rst_scl", int'(bus.scl_o), 1);
    check_eq("rst_sda", int'(bus.sda_o), 1);
    check_eq("rst_data", int'(bus.data_out), 0);
    check_eq("rst_berr", int'(bus.bus_error), 0);
    check_eq("rst_tout", int'(bus.timeout), 0);

    exec_bit("rd_data1", 2'b01, 1'b1, 0, 1'b0, 1'b0);
    exec_bit("rd_ack", 2'b10, 1'b0, 0, 1'b0, 1'b0);
    exec_bit("rd_nack", 2'b10, 1'b1, 0, 1'b0, 1'b0);
    exec_bit("stretch5", 2'b01, 1'b0, 5, 1'b0, 1'b0);
    exec_bit("stretch_max", 2'b01, 1'b1, St - 1, 1'b0, 1'b0);
    exec_bit("stuck", 2'b01, 1'b1, 1000, 1'b0, 1'b0);
    exec_bit("after_tout", 2'b10, 1'b0, 0, 1'b0, 1'b0);
    exec_bit("toggle", 2'b01, 1'b1, 0, 1'b1, 1'b0);

    // Reset during the first high-phase cycle, after an ACK left data_out=1.
    exec_bit("pre_rst", 2'b10, 1'b0, 0, 1'b0, 1'b0);
    run_bit(2'b01, 1'b1, 0, 1'b0, 1'b0, 2 * Div + 2, lat, low_cnt, sda_drv);
    check_eq("midrst_finish", int'(bus.finish), 1);
    check_eq("midrst_scl", int'(bus.scl_o), 1);
    check_eq("midrst_data", int'(bus.data_out), 0);
    check_eq("midrst_tout", int'(bus.timeout), 0);
    exec_bit("post_rst", 2'b01, 1'b0, 0, 1'b0, 1'b0);

    exec_nop("nop00", 2'b00);
    exec_nop("nop11", 2'b11);
    exec_bit("busy_go", 2'b10, 1'b1, 2, 1'b0, 1'b1);
    exec_nop("nop_after", 2'b00);

    for (int i = 0; i < 24; i++) begin
      logic [1:0] cmd;
      cmd = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      exec_bit($sformatf("rnd%0d", i), cmd, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
